// File: rtl/register_8_sequencer.sv
// Mode sequencer for the 8-bit pattern register: steps the 3-bit mode select through
// MODE_MIN..MODE_MAX, dwelling DWELL shift ticks per mode, with run/pause/single-step.
module register_8_sequencer #(
   parameter int unsigned TICK_DIV = 4,
   parameter int unsigned DWELL    = 3,
   parameter int unsigned MODE_MIN = 1,
   parameter int unsigned MODE_MAX = 4
) (
   input  logic       CLK_TOP,
   input  logic       RST_TOP,
   input  logic       RUN,
   input  logic       HOLD,
   input  logic       STEP,
   output logic [2:0] S_OUT,
   output logic       SHIFT_EN,
   output logic       LOAD,
   output logic       BUSY
);

   localparam int unsigned TICK_W  = $clog2(TICK_DIV);
   localparam int unsigned DWELL_W = $clog2(DWELL + 1);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0]  TICK_PRE   = TICK_W'(TICK_DIV - 2);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
   localparam logic [2:0]         MIN_SEL    = 3'(MODE_MIN);
   localparam logic [2:0]         MAX_SEL    = 3'(MODE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LDST  = 2'd1,
      ST_RUNST = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   state_t               r_state;
   logic [2:0]           r_s_out;
   logic                 r_shift_en;
   logic                 r_load;
   logic                 r_busy;
   logic [TICK_W-1:0]    r_tick;
   logic [DWELL_W-1:0]   r_dwell;

   logic [2:0]           w_s_adv;
   logic                 w_tick_last;
   logic                 w_tick_pre;
   logic                 w_dwell_last;

   // Next mode in the sequence; any out-of-range value snaps back to MODE_MIN.
   always_comb begin
      w_s_adv = MIN_SEL;
      if ((r_s_out != MAX_SEL) && (r_s_out >= MIN_SEL) && (r_s_out < MAX_SEL)) begin
         w_s_adv = r_s_out + 3'd1;
      end
   end

   assign w_tick_last  = (r_tick == TICK_LAST);
   assign w_tick_pre   = (r_tick == TICK_PRE);
   assign w_dwell_last = (r_dwell == DWELL_LAST);

   // The strobe is raised one edge early so SHIFT_EN is high while tick_cnt sits at TICK_DIV-1.
   always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
      if (RST_TOP) begin
         r_state    <= ST_IDLE;
         r_s_out    <= MIN_SEL;
         r_shift_en <= 1'b0;
         r_load     <= 1'b0;
         r_busy     <= 1'b0;
         r_tick     <= '0;
         r_dwell    <= '0;
      end else begin
         r_shift_en <= 1'b0;
         r_load     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               if (RUN) begin
                  r_state <= ST_LDST;
                  r_load  <= 1'b1;
                  r_busy  <= 1'b1;
                  r_tick  <= '0;
                  r_dwell <= '0;
               end else if (STEP) begin
                  r_s_out <= w_s_adv;
                  r_load  <= 1'b1;
               end
            end

            ST_LDST: begin
               r_tick  <= '0;
               r_dwell <= '0;
               if (!RUN) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_RUNST;
               end
            end

            ST_RUNST: begin
               if (!RUN) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_tick  <= '0;
                  r_dwell <= '0;
               end else if (HOLD) begin
                  r_state <= ST_PAUSE;
               end else if (w_tick_last) begin
                  r_tick <= '0;
                  if (w_dwell_last) begin
                     r_state <= ST_LDST;
                     r_load  <= 1'b1;
                     r_s_out <= w_s_adv;
                     r_dwell <= '0;
                  end else begin
                     r_dwell <= r_dwell + DWELL_W'(1);
                  end
               end else begin
                  r_tick     <= r_tick + TICK_W'(1);
                  r_shift_en <= w_tick_pre;
               end
            end

            ST_PAUSE: begin
               if (!RUN) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_tick  <= '0;
                  r_dwell <= '0;
               end else if (!HOLD) begin
                  r_state <= ST_RUNST;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign S_OUT    = r_s_out;
   assign SHIFT_EN = r_shift_en;
   assign LOAD     = r_load;
   assign BUSY     = r_busy;

endmodule

// File: tb/tb_register_8_sequencer.sv
// Directed bench for register_8_sequencer at default parameters (TICK_DIV=4, DWELL=3, modes 1..4).
module tb_register_8_sequencer;

   logic       clk;
   logic       rst;
   logic       run;
   logic       hold;
   logic       step;
   logic [2:0] s_out;
   logic       shift_en;
   logic       load;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   register_8_sequencer #(
      .TICK_DIV(4),
      .DWELL   (3),
      .MODE_MIN(1),
      .MODE_MAX(4)
   ) dut (
      .CLK_TOP (clk),
      .RST_TOP (rst),
      .RUN     (run),
      .HOLD    (hold),
      .STEP    (step),
      .S_OUT   (s_out),
      .SHIFT_EN(shift_en),
      .LOAD    (load),
      .BUSY    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] s, input logic sh,
                          input logic ld, input logic bz);
      chk({tag, ".s_out"},    32'(s_out),    32'(s));
      chk({tag, ".shift_en"}, 32'(shift_en), 32'(sh));
      chk({tag, ".load"},     32'(load),     32'(ld));
      chk({tag, ".busy"},     32'(busy),     32'(bz));
   endtask

   // Advance one rising edge and settle just after it.
   task automatic clk_step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] s_exp;
      logic       sh_exp;
      logic       ld_exp;

      rst = 1'b1; run = 1'b0; hold = 1'b0; step = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_out("reset", 3'd1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         clk_step();
         chk_out($sformatf("idle%0d", i), 3'd1, 1'b0, 1'b0, 1'b0);
      end

      // Run: LDST at edge 0, strobes at +4/+8/+12, new mode with LOAD every 13 edges.
      run = 1'b1;
      clk_step();
      chk_out("ldst0", 3'd1, 1'b0, 1'b1, 1'b1);
      for (int c = 1; c <= 52; c++) begin
         clk_step();
         ld_exp = ((c % 13) == 0);
         sh_exp = ((c % 13) != 0) && (((c % 13) % 4) == 0);
         s_exp  = 3'(1 + ((c / 13) % 4));
         chk_out($sformatf("run_c%0d", c), s_exp, sh_exp, ld_exp, 1'b1);
      end

      // Pause: strobe at 56, HOLD sampled high at edges 59..68, resume strobe at 71.
      for (int c = 53; c <= 76; c++) begin
         clk_step();
         sh_exp = (c == 56) || (c == 71) || (c == 75);
         ld_exp = (c == 76);
         s_exp  = (c == 76) ? 3'd2 : 3'd1;
         chk_out($sformatf("pause_c%0d", c), s_exp, sh_exp, ld_exp, 1'b1);
         if (c == 58) hold = 1'b1;
         if (c == 68) hold = 1'b0;
      end

      // RUN dropped during LDST.
      run = 1'b0;
      clk_step();
      chk_out("drop_ldst", 3'd2, 1'b0, 1'b0, 1'b0);

      // Manual steps 2 -> 3 -> 4 -> 1.
      step = 1'b1; clk_step(); step = 1'b0;
      chk_out("step3", 3'd3, 1'b0, 1'b1, 1'b0);
      clk_step();
      chk_out("step3_end", 3'd3, 1'b0, 1'b0, 1'b0);
      step = 1'b1; clk_step(); step = 1'b0;
      chk_out("step4", 3'd4, 1'b0, 1'b1, 1'b0);
      clk_step();
      step = 1'b1; clk_step(); step = 1'b0;
      chk_out("step_wrap", 3'd1, 1'b0, 1'b1, 1'b0);
      clk_step();
      chk_out("step_wrap_end", 3'd1, 1'b0, 1'b0, 1'b0);

      // RUN and STEP together: RUN wins, S_OUT unchanged.
      run = 1'b1; step = 1'b1;
      clk_step();
      step = 1'b0;
      chk_out("run_wins", 3'd1, 1'b0, 1'b1, 1'b1);
      clk_step();
      chk_out("runst_a1", 3'd1, 1'b0, 1'b0, 1'b1);
      step = 1'b1;
      clk_step();
      step = 1'b0;
      chk_out("step_busy", 3'd1, 1'b0, 1'b0, 1'b1);
      clk_step();
      chk_out("runst_a3", 3'd1, 1'b0, 1'b0, 1'b1);
      // Pending strobe at the next edge must be suppressed.
      run = 1'b0;
      clk_step();
      chk_out("run_fall", 3'd1, 1'b0, 1'b0, 1'b0);
      clk_step();
      chk_out("no_queue", 3'd1, 1'b0, 1'b0, 1'b0);

      // Mid-run asynchronous reset while in mode 2.
      run = 1'b1;
      clk_step();
      chk_out("ldst_b", 3'd1, 1'b0, 1'b1, 1'b1);
      repeat (13) clk_step();
      chk_out("mode2_b", 3'd2, 1'b0, 1'b1, 1'b1);
      repeat (4) clk_step();
      chk_out("mode2_shift", 3'd2, 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      chk_out("async_rst", 3'd1, 1'b0, 1'b0, 1'b0);
      clk_step();
      chk_out("rst_held", 3'd1, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      clk_step();
      chk_out("fresh_ldst", 3'd1, 1'b0, 1'b1, 1'b1);
      repeat (4) clk_step();
      chk_out("fresh_shift", 3'd1, 1'b1, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
